// File: rtl/reg_write_sequencer.sv
// Command-driven writer for one 16-bit FunSel/E/I/Q register: expands a
// handshaked command into FunSel cycles, then reads Q back and flags a mismatch.
module reg_write_sequencer #(
    parameter bit VERIFY = 1'b1,
    parameter int STEP_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [15:0] i_cmd_data,
    output logic [2:0]  o_funsel,
    output logic        o_e,
    output logic [15:0] o_i,
    input  logic [15:0] i_q,
    output logic        o_done,
    output logic        o_mismatch
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_HI, S_WR_LO, S_SEXT, S_CLR, S_STEP, S_CHECK
    } state_t;

    localparam logic [1:0] OP_LOAD16 = 2'b00;
    localparam logic [1:0] OP_SEXT8  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    state_t              r_state, w_next;
    logic [15:0]         r_data, r_exp;
    logic [STEP_W-1:0]   r_cnt;
    logic                r_mismatch;

    logic                w_accept;
    logic [STEP_W-1:0]   w_n;
    logic [15:0]         w_n16, w_exp;
    logic                w_miscmp;

    // Ready is also gated by reset so nothing is accepted while it is held.
    assign o_cmd_ready = (r_state == S_IDLE) && i_rst_n;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_n         = i_cmd_data[STEP_W-1:0];
    assign w_n16       = {{(16-STEP_W){1'b0}}, w_n};
    assign w_miscmp    = VERIFY ? (i_q != r_exp) : 1'b0;
    assign o_mismatch  = (r_state == S_CHECK) ? w_miscmp : r_mismatch;

    always_comb begin
        w_exp = 16'h0000;
        case (i_cmd_op)
            OP_LOAD16: w_exp = i_cmd_data;
            OP_SEXT8:  w_exp = {{8{i_cmd_data[7]}}, i_cmd_data[7:0]};
            OP_CLEAR:  w_exp = 16'h0000;
            default:   w_exp = i_cmd_data[15] ? (i_q + w_n16) : (i_q - w_n16);
        endcase
    end

    always_comb begin
        w_next   = r_state;
        o_e      = 1'b0;
        o_funsel = 3'b000;
        o_i      = 16'h0000;
        o_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_cmd_op)
                        OP_LOAD16: w_next = S_WR_HI;
                        OP_SEXT8:  w_next = S_SEXT;
                        OP_CLEAR:  w_next = S_CLR;
                        default:   w_next = (w_n != '0) ? S_STEP : S_CHECK;
                    endcase
                end
            end
            S_WR_HI: begin
                o_e      = 1'b1;
                o_funsel = 3'b110;
                o_i      = {8'h00, r_data[15:8]};
                w_next   = S_WR_LO;
            end
            S_WR_LO: begin
                o_e      = 1'b1;
                o_funsel = 3'b101;
                o_i      = {8'h00, r_data[7:0]};
                w_next   = S_CHECK;
            end
            S_SEXT: begin
                o_e      = 1'b1;
                o_funsel = 3'b111;
                o_i      = {8'h00, r_data[7:0]};
                w_next   = S_CHECK;
            end
            S_CLR: begin
                o_e      = 1'b1;
                o_funsel = 3'b011;
                w_next   = S_CHECK;
            end
            S_STEP: begin
                o_e      = 1'b1;
                o_funsel = {2'b00, r_data[15]};
                if (r_cnt == STEP_W'(1)) w_next = S_CHECK;
            end
            S_CHECK: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= 16'h0000;
            r_exp      <= 16'h0000;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= i_cmd_data;
                r_exp  <= w_exp;
                r_cnt  <= w_n;
            end
            if (r_state == S_STEP) r_cnt <= r_cnt - STEP_W'(1);
            if (r_state == S_CHECK) r_mismatch <= w_miscmp;
        end
    end
endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
- Command-driven initiator that drives the FunSel/E/I/Q interface of one 16-bit datapath register.
- Turns a single handshaked command (load, sign-extended load, clear, or N-step increment/decrement) into the correct sequence of FunSel cycles.
- After the sequence, reads Q back and flags any mismatch.
- Sits between the control unit and one register instance; it is that register's only writer while a command is active.

Parameters:
- VERIFY, 1, 1 = run a CHECK cycle that compares Q with the expected value; 0 = skip the compare, mismatch tied 0, done still pulses.
- STEP_W, 8, width of the step count taken from cmd_data[STEP_W-1:0]; must be 1..15.

Ports:
- Clock  in  1  single system clock, all state on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  2  00 LOAD16, 01 SEXT8, 10 CLEAR, 11 STEP.
- cmd_data  in  16  LOAD16: value; SEXT8: bits [7:0]; STEP: bit 15 = direction (1 inc, 0 dec), bits [STEP_W-1:0] = N.
- FunSel  out  3  register function select.
- E  out  1  register enable.
- I  out  16  register data input.
- Q  in  16  register output, read back.
- done  out  1  one-cycle pulse at command completion.
- mismatch  out  1  valid with done; 1 = Q differed from expected.

Behaviour:
- Reset (Reset == 0 at an edge): state = IDLE, E = 0, FunSel = 000, I = 0, done = 0, mismatch = 0, counters cleared. While Reset is held low, cmd_ready = 0.
- Outputs FunSel/E/I are decoded from registered state only. There is no combinational path from cmd_* to the register interface.
- When E = 0, FunSel = 000 and I = 0.
- Accept edge:
  - Latch cmd_op and cmd_data.
  - Snapshot Q into base.
  - Compute expected:
    - LOAD16: cmd_data.
    - SEXT8: {{8{d[7]}}, d[7:0]}.
    - CLEAR: 0.
    - STEP: base ± N, modulo 2^16.
- States and transitions:
  - IDLE: cmd_ready = 1. On accept: LOAD16 -> WR_HI, SEXT8 -> SEXT, CLEAR -> CLR. STEP with N != 0 -> STEP. STEP with N == 0 -> CHECK, or DONE_ONLY when VERIFY = 0.
  - WR_HI: E = 1, FunSel = 110, I = {8'h00, d[15:8]}. Next: WR_LO.
  - WR_LO: E = 1, FunSel = 101, I = {8'h00, d[7:0]}. Next: CHECK.
  - SEXT: E = 1, FunSel = 111, I = {8'h00, d[7:0]}. Next: CHECK.
  - CLR: E = 1, FunSel = 011, I = 0. Next: CHECK.
  - STEP: E = 1, FunSel = 001 (inc) or 000 (dec). The remaining count is loaded with N and decrements each cycle; leave to CHECK after exactly N E-cycles.
  - CHECK: E = 0. Q now reflects the final write. done = 1, mismatch = (Q != expected). Next: IDLE.
  - When VERIFY = 0, CHECK becomes a done-only cycle with mismatch = 0.
- Latency from accept edge to the done cycle:
  - LOAD16: 3.
  - SEXT8 and CLEAR: 2.
  - STEP: N + 1; N = 0 gives 1 with zero E cycles.
- cmd_ready is low from the accept edge through the done cycle. A back-to-back command can be accepted on the first edge after done.
- cmd_valid or cmd_data changes while busy are ignored.
- STEP wraps silently: 0xFFFF + 1 = 0x0000 and 0x0000 − 1 = 0xFFFF. Expected uses the same wrap.
- Reset mid-command:
  - The operation is abandoned and E = 0 from the next cycle.
  - No done pulse; the register keeps any partial write.
- mismatch holds its value until the next done pulse; reset clears it.

Test Plan:
- Q = 0x1234, LOAD16 0xA55A -> E cycles (110, I = 0x00A5), (101, I = 0x005A); Q = 0xA55A; done 3 cycles after accept; mismatch = 0.
- SEXT8 cmd_data = 0x0080 -> one E cycle FunSel = 111; Q = 0xFF80; done at +2. Repeat with 0x007F -> Q = 0x007F.
- Q = 0xFFFE, STEP inc N = 3 -> exactly 3 E cycles of 001; Q = 0x0001; done at +4; mismatch = 0. STEP dec N = 0 -> no E cycle, done at +1, Q unchanged.
- CLEAR with bench Q forced stuck at 0x00FF -> one E cycle FunSel = 011; done at +2 with mismatch = 1. Next good command clears mismatch.
- Reset pulled low in the cycle after WR_HI -> E = 0 next cycle, no done; after release cmd_ready = 1; a new LOAD16 0x0001 completes normally.
- cmd_valid held high continuously with alternating ops -> one accept per done; cmd_ready never high while busy; outputs unchanged by cmd_data toggling mid-command.
